uart_pixel_loader: RTL

//  Frame controller between the UART receiver and the WS2812b pixel buffer. Consumes received

---
 rtl/uart_pixel_loader_pkg.sv | 28 ++
 rtl/uart_byte_timeout.sv | 40 ++++
 rtl/uart_pixel_loader.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/uart_pixel_loader_pkg.sv
// Shared types and constants for the UART pixel frame loader.
package uart_pixel_loader_pkg;

  localparam int unsigned GRB_W         = 24;
  localparam int unsigned CLK_HZ        = 100_000_000;
  localparam int unsigned BAUD          = 115_200;
  localparam int unsigned CLK_PER_BIT   = CLK_HZ / BAUD;
  localparam int unsigned BITS_PER_BYTE = 10;
  localparam int unsigned TIMEOUT_BYTES = 10;
  localparam int unsigned TIMEOUT_CYC_DEF = CLK_PER_BIT * BITS_PER_BYTE * TIMEOUT_BYTES;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LEN  = 2'd1,
    S_PIX  = 2'd2,
    S_CSUM = 2'd3
  } state_e;

  // Pixel RAM word, G in the top byte
  typedef struct packed {
    logic [7:0] g;
    logic [7:0] r;
    logic [7:0] b;
  } grb_t;

endpackage

// File: rtl/uart_byte_timeout.sv
// Inter-byte watchdog: counts enabled cycles since the last clear.
module uart_byte_timeout
  import uart_pixel_loader_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired_c
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next count: clear wins, otherwise count up and hold at the last value
  always_comb begin
    cnt_d = cnt_q;
    if (i_clr) begin
      cnt_d = '0;
    end else if (i_en && (cnt_q != CNT_LAST)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Counter register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_expired_c = i_en && (cnt_q == CNT_LAST);

endmodule

// File: rtl/uart_pixel_loader.sv
// Parses SYNC/N/GRB.../CSUM frames from the UART and loads the pixel RAM.
module uart_pixel_loader
  import uart_pixel_loader_pkg::*;
#(
  parameter int unsigned NUM_LEDS    = 64,
  parameter int unsigned ADDR_W      = 6,
  parameter logic [7:0]  SYNC_BYTE   = SYNC_BYTE_DEF,
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_rx_dv,
  input  logic [7:0]        i_rx_byte,
  input  logic              i_drv_busy,
  output logic              o_wr_en,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic [GRB_W-1:0]  o_wr_data,
  output logic              o_refresh_req,
  output logic              o_frame_err,
  output logic              o_drop,
  output logic              o_busy
);

  localparam int unsigned PIX_W = ADDR_W + 1;

  state_e             state_q, state_d;
  logic [PIX_W-1:0]   n_q, n_d;
  logic [PIX_W-1:0]   pix_q, pix_d;
  logic [1:0]         idx_q, idx_d;
  logic [7:0]         g_q, g_d;
  logic [7:0]         r_q, r_d;
  logic [7:0]         csum_q, csum_d;
  logic               wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
  grb_t               wr_data_q, wr_data_d;
  logic               refresh_q, refresh_d;
  logic               err_q, err_d;
  logic               drop_q, drop_d;
  logic               busy_q, busy_d;

  logic               tmo_clr_c;
  logic               tmo_en_c;
  logic               tmo_expired_c;

  assign tmo_en_c  = (state_q != S_IDLE);
  assign tmo_clr_c = i_rx_dv || (state_q == S_IDLE);

  uart_byte_timeout #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timeout (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_clr       (tmo_clr_c),
    .i_en        (tmo_en_c),
    .o_expired_c (tmo_expired_c)
  );

  // Frame parser: next state, checksum, pixel assembly and output pulses
  always_comb begin
    state_d   = state_q;
    n_d       = n_q;
    pix_d     = pix_q;
    idx_d     = idx_q;
    g_d       = g_q;
    r_d       = r_q;
    csum_d    = csum_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    wr_en_d   = 1'b0;
    refresh_d = 1'b0;
    err_d     = 1'b0;
    drop_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (i_rx_dv && (i_rx_byte == SYNC_BYTE)) begin
          if (i_drv_busy) begin
            drop_d = 1'b1;
          end else begin
            state_d = S_LEN;
          end
        end
      end

      S_LEN: begin
        if (i_rx_dv) begin
          if ((i_rx_byte == 8'd0) || (32'(i_rx_byte) > NUM_LEDS)) begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end else begin
            n_d     = PIX_W'(i_rx_byte);
            csum_d  = i_rx_byte;
            pix_d   = '0;
            idx_d   = 2'd0;
            state_d = S_PIX;
          end
        end
      end

      S_PIX: begin
        if (i_rx_dv) begin
          csum_d = csum_q ^ i_rx_byte;
          case (idx_q)
            2'd0: begin
              g_d   = i_rx_byte;
              idx_d = 2'd1;
            end
            2'd1: begin
              r_d   = i_rx_byte;
              idx_d = 2'd2;
            end
            default: begin
              wr_en_d   = 1'b1;
              wr_addr_d = pix_q[ADDR_W-1:0];
              wr_data_d = '{g: g_q, r: r_q, b: i_rx_byte};
              idx_d     = 2'd0;
              pix_d     = pix_q + PIX_W'(1);
              if ((pix_q + PIX_W'(1)) == n_q) begin
                state_d = S_CSUM;
              end
            end
          endcase
        end
      end

      S_CSUM: begin
        if (i_rx_dv) begin
          if (i_rx_byte == csum_q) begin
            refresh_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Inter-byte silence aborts a frame; a strobe in the same cycle takes priority
    if ((state_q != S_IDLE) && !i_rx_dv && tmo_expired_c) begin
      err_d   = 1'b1;
      state_d = S_IDLE;
    end

    busy_d = (state_d != S_IDLE);
  end

  // State, datapath and output registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= S_IDLE;
      n_q       <= '0;
      pix_q     <= '0;
      idx_q     <= '0;
      g_q       <= '0;
      r_q       <= '0;
      csum_q    <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      refresh_q <= 1'b0;
      err_q     <= 1'b0;
      drop_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      n_q       <= n_d;
      pix_q     <= pix_d;
      idx_q     <= idx_d;
      g_q       <= g_d;
      r_q       <= r_d;
      csum_q    <= csum_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      refresh_q <= refresh_d;
      err_q     <= err_d;
      drop_q    <= drop_d;
      busy_q    <= busy_d;
    end
  end

  assign o_wr_en       = wr_en_q;
  assign o_wr_addr     = wr_addr_q;
  assign o_wr_data     = wr_data_q;
  assign o_refresh_req = refresh_q;
  assign o_frame_err   = err_q;
  assign o_drop        = drop_q;
  assign o_busy        = busy_q;

endmodule
